rf_write_arbiter: RTL

Shares the register file's single write port between two writeback sources. Source A is the main pipeline WB stage: it is never back-pressured and always has priority. Source B is the multi-cycle unit (MDU / late load return): it uses a valid/ready handshake and is held in a small buffer. The block sits between the WB stage and REGISTER_FILE, registers the selected write, and publishes a pending-write scoreboard to the hazard unit.

---
 rtl/rf_arb_pkg.sv | 25 ++
 rtl/rf_arb_fifo.sv | 71 +++++++
 rtl/rf_write_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths, buffer entry type and default parameters for
// the register-file write-port arbiter and its B-side buffer.
package rf_arb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  localparam int DEFAULT_DEPTH        = 2;
  localparam int DEFAULT_STARVE_LIMIT = 8;

  // One buffered writeback: destination register and data
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } rf_entry_t;

  // One-hot decode of a register number onto the scoreboard vector
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    logic [NREGS-1:0] v;
    v = {{(NREGS-1){1'b0}}, 1'b1} << r;
    return v;
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// rf_arb_fifo: DEPTH-entry FIFO holding B-side writebacks until the write
// port is free. Exposes the occupancy count, the head entry and, per slot,
// a valid flag and destination register so the top can build the scoreboard.
// The caller never pushes when full nor pops when empty.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  rf_entry_t                          push_entry,
  input  logic                               pop,
  output logic [$clog2(DEPTH):0]             count,
  output rf_entry_t                          head,
  output logic [DEPTH-1:0]                   entry_valid,
  output logic [DEPTH-1:0][REG_W-1:0]        entry_reg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rf_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful under a valid flag, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head = mem[rd_ptr];

  // Slot i is occupied when its distance from the read pointer is below count
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset      = '0;
    entry_valid = '0;
    entry_reg   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, offset} < count);
      entry_reg[i]   = mem[i].rd;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between
// the pipeline WB stage (A, always wins, never back-pressured) and the
// multi-cycle unit (B, valid/ready into a small FIFO). The chosen write is
// registered for one cycle, and a pending-write scoreboard (Busy) is
// published for the hazard unit.
// Optional feature macro: RF_ARB_STARVE_EN builds the B starvation counter,
// Pipe_Stall request and sticky Stall_Err flag; otherwise both are tied 0.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              A_Write,
  input  logic [REG_W-1:0]  A_Reg,
  input  logic [DATA_W-1:0] A_Data,
  input  logic              B_Valid,
  output logic              B_Ready,
  input  logic [REG_W-1:0]  B_Reg,
  input  logic [DATA_W-1:0] B_Data,
  output logic              Reg_Write,
  output logic [REG_W-1:0]  Write_Reg,
  output logic [DATA_W-1:0] Write_Data,
  output logic [NREGS-1:0]  Busy,
  output logic              Pipe_Stall,
  output logic              Stall_Err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Parameter sanity: DEPTH must be a power of two >= 2, limit at least 1
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("rf_write_arbiter: unsupported DEPTH/STARVE_LIMIT");
  end

  logic                        live_a;
  logic                        push;
  logic                        pop;
  logic                        fifo_empty;
  logic [CNT_W-1:0]            fifo_count;
  rf_entry_t                   fifo_head;
  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH-1:0][REG_W-1:0] entry_reg;
  logic [NREGS-1:0]            busy_v;

  // A register-0 write is architecturally a no-op, so it never claims the port
  assign live_a     = A_Write & (A_Reg != {REG_W{1'b0}});
  assign fifo_empty = (fifo_count == {CNT_W{1'b0}});
  // Ready comes from the registered count: a full FIFO refuses even while popping
  assign B_Ready    = (fifo_count < CNT_W'(DEPTH));
  // B writes to register 0 are handshaken but dropped here
  assign push       = B_Valid & B_Ready & (B_Reg != {REG_W{1'b0}});
  assign pop        = ~fifo_empty & ~live_a;

  rf_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (Clk),
    .reset       (Reset),
    .push        (push),
    .push_entry  ('{rd: B_Reg, data: B_Data}),
    .pop         (pop),
    .count       (fifo_count),
    .head        (fifo_head),
    .entry_valid (entry_valid),
    .entry_reg   (entry_reg)
  );

  // Output stage: A has priority, else drain FIFO head, else idle holding addr/data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Reg_Write  <= 1'b0;
      Write_Reg  <= '0;
      Write_Data <= '0;
    end else if (live_a) begin
      Reg_Write  <= 1'b1;
      Write_Reg  <= A_Reg;
      Write_Data <= A_Data;
    end else if (pop) begin
      Reg_Write  <= 1'b1;
      Write_Reg  <= fifo_head.rd;
      Write_Data <= fifo_head.data;
    end else begin
      Reg_Write  <= 1'b0;
    end
  end

  // Scoreboard: every buffered destination plus the in-flight output write
  always_comb begin
    busy_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_v = busy_v | (entry_valid[i] ? reg_onehot(entry_reg[i]) : {NREGS{1'b0}});
    end
    busy_v = busy_v | (Reg_Write ? reg_onehot(Write_Reg) : {NREGS{1'b0}});
    Busy   = busy_v & ~{{(NREGS-1){1'b0}}, 1'b1};
  end

`ifdef RF_ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] cnt;

  // Starvation counter: counts cycles the FIFO head waits, saturating at LIMIT
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (pop || fifo_empty) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + SC_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign Pipe_Stall = (cnt == LIMIT);

  // Sticky error: the pipeline wrote through a stall request
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Stall_Err <= 1'b0;
    end else if (Pipe_Stall && live_a) begin
      Stall_Err <= 1'b1;
    end else begin
      Stall_Err <= Stall_Err;
    end
  end
`else
  assign Pipe_Stall = 1'b0;
  assign Stall_Err  = 1'b0;
`endif

endmodule
